alu_seq: RTL

// - Registered, handshaked successor of the combinational ALU: accepts one operation per

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_shift_add_mul.sv | 65 ++++++
 rtl/alu_seq.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM states and flag bundle shared by the sequential ALU.
package alu_pkg;
    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SLL = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_SRA = 6'b000111;
    localparam logic [5:0] OP_SLT = 6'b101010;
    localparam logic [5:0] OP_MUL = 6'b011000;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_RESP} alu_state_e;

    typedef struct packed {
        logic overflow;
        logic carry;
        logic zero;
        logic negative;
        logic illegal;
    } alu_flags_t;
endpackage

// File: rtl/alu_shift_add_mul.sv
// alu_shift_add_mul: unsigned shift-add multiplier, NB_DATA iterations per product.
module alu_shift_add_mul #(
    parameter int NB_DATA = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic [NB_DATA-1:0]     i_a,
    input  logic [NB_DATA-1:0]     i_b,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [2*NB_DATA-1:0]   o_product
);
    localparam int NB_CNT = $clog2(NB_DATA + 1);

    logic                 busy_q, busy_d;
    logic [NB_CNT-1:0]    cnt_q, cnt_d;
    logic [2*NB_DATA-1:0] mcand_q, mcand_d, acc_q, acc_d;
    logic [NB_DATA-1:0]   mplier_q, mplier_d;

    always_comb begin
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        if (i_start) begin
            busy_d   = 1'b1;
            cnt_d    = NB_CNT'(NB_DATA);
            mcand_d  = {{NB_DATA{1'b0}}, i_a};
            mplier_d = i_b;
            acc_d    = '0;
        end else if (busy_q) begin
            // done is seen for one cycle with cnt at zero, then the unit goes idle
            if (cnt_q != '0) begin
                acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - 1'b1;
            end else begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
        end
    end

    assign o_busy    = busy_q;
    assign o_done    = busy_q && cnt_q == '0;
    assign o_product = acc_q;
endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with registered result/flags and a multi-cycle multiplier.
module alu_seq import alu_pkg::*; #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [NB_DATA-1:0] i_data_a,
    input  logic [NB_DATA-1:0] i_data_b,
    input  logic [NB_OP-1:0]   i_operation_code,
    input  logic               i_signed,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [NB_DATA-1:0] o_result,
    output logic               o_overflow,
    output logic               o_carry,
    output logic               o_zero,
    output logic               o_negative,
    output logic               o_illegal
);
    localparam int NB_SHAMT = $clog2(NB_DATA);
    localparam int MSB = NB_DATA - 1;
    localparam logic [NB_DATA-1:0] SH_LIM = NB_DATA'(NB_DATA);

    alu_state_e           state_q, state_d;
    logic [NB_DATA-1:0]   result_q, result_d;
    alu_flags_t           flags_q, flags_d;
    logic                 mul_sgn_q, mul_sgn_d, mul_neg_q, mul_neg_d;
    logic [NB_DATA:0]     sum, diff;
    logic [NB_SHAMT-1:0]  shamt;
    logic                 big, lt;
    logic [NB_DATA-1:0]   alu_res;
    logic                 alu_ovf, alu_carry, alu_ill;
    logic [NB_DATA-1:0]   mag_a, mag_b;
    logic                 mul_start, mul_busy, mul_done, mul_ovf;
    logic [2*NB_DATA-1:0] mul_prod, mul_p;
    logic [NB_DATA:0]     mul_hi;

    assign sum   = {1'b0, i_data_a} + {1'b0, i_data_b};
    assign diff  = {1'b0, i_data_a} - {1'b0, i_data_b};
    assign shamt = i_data_b[NB_SHAMT-1:0];
    assign big   = i_data_b >= SH_LIM;
    assign lt    = i_signed ? $signed(i_data_a) < $signed(i_data_b) : i_data_a < i_data_b;

    always_comb begin
        alu_res   = '0;
        alu_ovf   = 1'b0;
        alu_carry = 1'b0;
        alu_ill   = 1'b0;
        case (i_operation_code)
            OP_ADD: begin
                alu_res   = sum[MSB:0];
                alu_carry = sum[NB_DATA];
                alu_ovf   = i_signed ? (i_data_a[MSB] == i_data_b[MSB]) && (sum[MSB] != i_data_a[MSB])
                                     : sum[NB_DATA];
            end
            OP_SUB: begin
                alu_res   = diff[MSB:0];
                alu_carry = diff[NB_DATA];
                alu_ovf   = i_signed ? (i_data_a[MSB] != i_data_b[MSB]) && (diff[MSB] != i_data_a[MSB])
                                     : diff[NB_DATA];
            end
            OP_AND:  alu_res = i_data_a & i_data_b;
            OP_OR:   alu_res = i_data_a | i_data_b;
            OP_XOR:  alu_res = i_data_a ^ i_data_b;
            OP_NOR:  alu_res = ~(i_data_a | i_data_b);
            OP_SLL:  alu_res = big ? '0 : i_data_a << shamt;
            OP_SRL:  alu_res = big ? '0 : i_data_a >> shamt;
            OP_SRA:  alu_res = big ? {NB_DATA{i_data_a[MSB]}} : NB_DATA'($signed(i_data_a) >>> shamt);
            OP_SLT:  alu_res = {{(NB_DATA-1){1'b0}}, lt};
            OP_MUL:  alu_res = '0;
            default: alu_ill = 1'b1;
        endcase
    end

    // Signed products run on magnitudes; the sign is restored once the product is ready
    assign mag_a     = (i_signed && i_data_a[MSB]) ? -i_data_a : i_data_a;
    assign mag_b     = (i_signed && i_data_b[MSB]) ? -i_data_b : i_data_b;
    assign mul_start = state_q == S_IDLE && i_valid && i_operation_code == OP_MUL && !mul_busy;
    assign mul_p     = mul_neg_q ? -mul_prod : mul_prod;
    assign mul_hi    = mul_p[2*NB_DATA-1:MSB];
    assign mul_ovf   = mul_sgn_q ? !(&mul_hi || !(|mul_hi)) : |mul_p[2*NB_DATA-1:NB_DATA];

    alu_shift_add_mul #(.NB_DATA(NB_DATA)) u_mul (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_start   (mul_start),
        .i_a       (mag_a),
        .i_b       (mag_b),
        .o_busy    (mul_busy),
        .o_done    (mul_done),
        .o_product (mul_prod)
    );

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        flags_d   = flags_q;
        mul_sgn_d = mul_sgn_q;
        mul_neg_d = mul_neg_q;
        case (state_q)
            S_IDLE: if (mul_start) begin
                state_d   = S_MUL;
                mul_sgn_d = i_signed;
                mul_neg_d = i_signed && (i_data_a[MSB] ^ i_data_b[MSB]);
            end else if (i_valid) begin
                state_d  = S_RESP;
                result_d = alu_res;
                flags_d  = '{alu_ovf, alu_carry, alu_res == '0, alu_res[MSB], alu_ill};
            end
            S_MUL: if (mul_done) begin
                state_d  = S_RESP;
                result_d = mul_p[MSB:0];
                flags_d  = '{mul_ovf, 1'b0, mul_p[MSB:0] == '0, mul_p[MSB], 1'b0};
            end
            S_RESP: if (i_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            result_q  <= '0;
            flags_q   <= '0;
            mul_sgn_q <= 1'b0;
            mul_neg_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            flags_q   <= flags_d;
            mul_sgn_q <= mul_sgn_d;
            mul_neg_q <= mul_neg_d;
        end
    end

    assign o_ready    = state_q == S_IDLE;
    assign o_valid    = state_q == S_RESP;
    assign o_result   = result_q;
    assign o_overflow = flags_q.overflow;
    assign o_carry    = flags_q.carry;
    assign o_zero     = flags_q.zero;
    assign o_negative = flags_q.negative;
    assign o_illegal  = flags_q.illegal;
endmodule
